// File: rtl/approx_mult_ctrl.sv
// Sequencing FSM for the approximate 16x16 multiplier: load, normalise, 8x8 multiply, de-normalise.
// Optional macro CAD_MULT_CYCLE_CNT_EN adds an op_cycles output reporting the cycles of the last op.
module approx_mult_ctrl #(
  parameter int unsigned OP_W  = 16,
  parameter int unsigned CNT_W = 3,
  parameter int unsigned RC_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             msb_a,
  input  logic             msb_b,
  input  logic             co_A,
  input  logic             co_B,
  input  logic [CNT_W-1:0] count_a,
  input  logic [CNT_W-1:0] count_b,
  output logic             ld_a,
  output logic             ld_b,
  output logic             cnt_clean_a,
  output logic             cnt_clean_b,
  output logic             shift_en_a,
  output logic             shift_en_b,
  output logic             cnt_en_a,
  output logic             cnt_en_b,
  output logic             ld_res,
  output logic             shift_en_res,
`ifdef CAD_MULT_CYCLE_CNT_EN
  output logic [7:0]       op_cycles,
`endif
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StNorm,
    StMult,
    StRshift,
    StDone
  } state_e;

  state_e          state_q;
  logic [RC_W-1:0] rcnt_q;
  logic            stop_a;
  logic            stop_b;
  logic [RC_W-1:0] res_shamt;

  // An operand stops shifting once normalised or once its counter saturates.
  assign stop_a    = msb_a | co_A;
  assign stop_b    = msb_b | co_B;
  assign res_shamt = RC_W'(OP_W) - RC_W'(count_a) - RC_W'(count_b);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      rcnt_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_q <= StLoad;
        end
        StLoad: begin
          state_q <= StNorm;
        end
        StNorm: begin
          if (stop_a && stop_b) state_q <= StMult;
        end
        StMult: begin
          rcnt_q  <= res_shamt;
          state_q <= StRshift;
        end
        StRshift: begin
          rcnt_q <= rcnt_q - RC_W'(1);
          if (rcnt_q == RC_W'(1)) state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    ld_a         = 1'b0;
    ld_b         = 1'b0;
    cnt_clean_a  = 1'b0;
    cnt_clean_b  = 1'b0;
    shift_en_a   = 1'b0;
    shift_en_b   = 1'b0;
    cnt_en_a     = 1'b0;
    cnt_en_b     = 1'b0;
    ld_res       = 1'b0;
    shift_en_res = 1'b0;
    done         = 1'b0;
    busy         = (state_q != StIdle);
    unique case (state_q)
      StLoad: begin
        ld_a        = 1'b1;
        ld_b        = 1'b1;
        cnt_clean_a = 1'b1;
        cnt_clean_b = 1'b1;
      end
      StNorm: begin
        shift_en_a = ~stop_a;
        cnt_en_a   = ~stop_a;
        shift_en_b = ~stop_b;
        cnt_en_b   = ~stop_b;
      end
      StMult:   ld_res       = 1'b1;
      StRshift: shift_en_res = 1'b1;
      StDone:   done         = 1'b1;
      default: ;
    endcase
  end

`ifdef CAD_MULT_CYCLE_CNT_EN
  logic [7:0] cyc_q;
  logic [7:0] op_cycles_q;

  // cyc_q lags by one, so the latch on DONE entry adds the current cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_q       <= '0;
      op_cycles_q <= '0;
    end else begin
      if (state_q == StIdle && start) begin
        cyc_q <= '0;
      end else if (state_q != StIdle) begin
        cyc_q <= cyc_q + 8'd1;
      end
      if (state_q == StRshift && rcnt_q == RC_W'(1)) begin
        op_cycles_q <= cyc_q + 8'd1;
      end
    end
  end

  assign op_cycles = op_cycles_q;
`endif

endmodule

// File: tb/tb_approx_mult_ctrl.sv
// Directed bench for approx_mult_ctrl with a small behavioural datapath driving msb/co/count.
module tb_approx_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       msb_a, msb_b, co_A, co_B;
  logic [2:0] count_a, count_b;
  logic       ld_a, ld_b, cnt_clean_a, cnt_clean_b, shift_en_a, shift_en_b;
  logic       cnt_en_a, cnt_en_b, ld_res, shift_en_res, busy, done;
`ifdef CAD_MULT_CYCLE_CNT_EN
  logic [7:0] op_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] op_a = '0, op_b = '0;
  logic [15:0] a_q = '0, b_q = '0;
  logic [2:0]  cnt_a_q = '0, cnt_b_q = '0;

  always #5 clk = ~clk;

  approx_mult_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .msb_a        (msb_a),
    .msb_b        (msb_b),
    .co_A         (co_A),
    .co_B         (co_B),
    .count_a      (count_a),
    .count_b      (count_b),
    .ld_a         (ld_a),
    .ld_b         (ld_b),
    .cnt_clean_a  (cnt_clean_a),
    .cnt_clean_b  (cnt_clean_b),
    .shift_en_a   (shift_en_a),
    .shift_en_b   (shift_en_b),
    .cnt_en_a     (cnt_en_a),
    .cnt_en_b     (cnt_en_b),
    .ld_res       (ld_res),
    .shift_en_res (shift_en_res),
`ifdef CAD_MULT_CYCLE_CNT_EN
    .op_cycles    (op_cycles),
`endif
    .busy         (busy),
    .done         (done)
  );

  // Behavioural operand registers and normalisation counters.
  always_ff @(posedge clk) begin
    if (ld_a) a_q <= op_a;
    else if (shift_en_a) a_q <= {a_q[14:0], 1'b0};
    if (ld_b) b_q <= op_b;
    else if (shift_en_b) b_q <= {b_q[14:0], 1'b0};
    if (cnt_clean_a) cnt_a_q <= '0;
    else if (cnt_en_a) cnt_a_q <= cnt_a_q + 3'd1;
    if (cnt_clean_b) cnt_b_q <= '0;
    else if (cnt_en_b) cnt_b_q <= cnt_b_q + 3'd1;
  end

  assign msb_a   = a_q[15];
  assign msb_b   = b_q[15];
  assign co_A    = &cnt_a_q;
  assign co_B    = &cnt_b_q;
  assign count_a = cnt_a_q;
  assign count_b = cnt_b_q;

  function automatic logic [11:0] all_outs();
    return {ld_a, ld_b, cnt_clean_a, cnt_clean_b, shift_en_a, shift_en_b,
            cnt_en_a, cnt_en_b, ld_res, shift_en_res, busy, done};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Runs one operation; edge 0 is the edge that samples start.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input int ea, input int eb, input int er, input int ed,
                        input bit hold);
    int na = 0, nb = 0, nr = 0, nlr = 0, nld = 0, de = -1, e = 0;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    while (de < 0 && e < 60) begin
      @(negedge clk);
      na  += int'(shift_en_a);
      nb  += int'(shift_en_b);
      nr  += int'(shift_en_res);
      nlr += int'(ld_res);
      nld += int'(ld_a);
      if (done) de = e;
      @(posedge clk);
      e++;
    end
    #1;
    check_eq({tag, " shift_a"}, na, ea);
    check_eq({tag, " shift_b"}, nb, eb);
    check_eq({tag, " shift_res"}, nr, er);
    check_eq({tag, " ld_res"}, nlr, 1);
    check_eq({tag, " ld_a"}, nld, 1);
    check_eq({tag, " done_edge"}, de, ed);
    if (!hold) begin
      check_eq({tag, " busy_after"}, busy, 0);
    end else begin
      check_eq({tag, " idle_after"}, {busy, ld_a}, 0);
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq({tag, " reload"}, ld_a, 1);
      e = 0;
      while (busy && e < 60) begin
        @(posedge clk);
        #1;
        e++;
      end
      check_eq({tag, " reload_idle"}, busy, 0);
    end
  endtask

  initial begin
    int e;
    logic seen_done;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset outs", all_outs(), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle outs", all_outs(), 0);

    run_op("norm both", 16'h8000, 16'h8000, 0, 0, 16, 19, 1'b0);
`ifdef CAD_MULT_CYCLE_CNT_EN
    check_eq("op_cycles", op_cycles, 19);
    repeat (5) @(posedge clk);
    #1;
    check_eq("op_cycles hold", op_cycles, 19);
`endif
    run_op("co_A stop", 16'h0100, 16'h8000, 7, 0, 9, 19, 1'b0);
    run_op("small ops", 16'h0001, 16'h0001, 7, 7, 2, 12, 1'b0);
    run_op("start held", 16'h8000, 16'h8000, 0, 0, 16, 19, 1'b1);

    // Abort mid-RSHIFT with reset.
    @(negedge clk);
    op_a  = 16'h8000;
    op_b  = 16'h8000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = 0;
    while (!shift_en_res && e < 40) begin
      @(posedge clk);
      #1;
      e++;
    end
    check_eq("reach rshift", shift_en_res, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort outs", all_outs(), 0);
    @(negedge clk);
    rst = 1'b1;
    seen_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check_eq("abort no done", seen_done, 0);
    run_op("after abort", 16'h0100, 16'h8000, 7, 0, 9, 19, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_mult_ctrl.md
Name: approx_mult_ctrl

Overview:
- FSM controller that sequences the approximate 16x16 multiplier datapath.
- Loads both operands and normalises each one by left-shifting until its MSB is 1 or its 3-bit shift counter saturates.
- Triggers the 8x8 multiply of the upper bytes, then left-shifts the product back to full scale.
- Sits between the top-level start/done handshake and the datapath control pins.

Parameters:
- OP_W, 16, operand width; result de-normalise amount = OP_W - count_a - count_b.
- CNT_W, 3, width of the datapath normalisation counters (count_a, count_b).
- RC_W, 5, width of the internal result-shift down-counter; must hold OP_W.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request a new multiply; sampled only in IDLE.
- msb_a  in  1  current bit OP_W-1 of operand-A shift register.
- msb_b  in  1  current bit OP_W-1 of operand-B shift register.
- co_A  in  1  counter-A carry-out; high when count_a = 2^CNT_W-1.
- co_B  in  1  counter-B carry-out; high when count_b = 2^CNT_W-1.
- count_a  in  CNT_W  number of shifts applied to A.
- count_b  in  CNT_W  number of shifts applied to B.
- ld_a, ld_b  out  1  parallel-load the operand registers.
- cnt_clean_a, cnt_clean_b  out  1  clear the normalisation counters.
- shift_en_a, shift_en_b  out  1  shift the operand registers left by 1.
- cnt_en_a, cnt_en_b  out  1  increment the normalisation counters.
- ld_res  out  1  load the product into the result register.
- shift_en_res  out  1  shift the result register left by 1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; result is valid.

Behaviour:
- States: IDLE, LOAD, NORM, MULT, RSHIFT, DONE. The state register is the only sequential element besides rcnt (and the optional cycle counter).
- Outputs are combinational from the state plus the NORM gating terms. All outputs are 0 in IDLE, so every output reads 0 from the reset edge onward.
- rst = 0 at any edge: state <= IDLE, rcnt <= 0. This applies mid-operation; the in-flight operation is abandoned and no done pulse is produced.
- IDLE: start = 1 moves to LOAD; start = 0 stays in IDLE. start is ignored in all other states, with no queuing.
- LOAD (1 cycle): ld_a = ld_b = cnt_clean_a = cnt_clean_b = 1, then go to NORM.
- NORM, per-operand stop conditions:
  - stop_a = msb_a | co_A; shift_en_a = cnt_en_a = ~stop_a.
  - stop_b and shift_en_b / cnt_en_b are defined the same way from msb_b and co_B.
  - The two operands shift independently in the same cycles.
- NORM exit: when stop_a & stop_b, go to MULT. Dwell = max(sa, sb) + 1 cycles, where sa and sb are the final count values.
- MULT (1 cycle): ld_res = 1; rcnt <= OP_W - count_a - count_b (range 2..16); go to RSHIFT.
- RSHIFT: shift_en_res = 1 every cycle; rcnt decrements. When rcnt = 1, go to DONE, so exactly rcnt shifts are issued.
- DONE (1 cycle): done = 1, then go to IDLE. A start in the following IDLE cycle is accepted, so back-to-back operations are legal.
- Latency: numbering the start-sampling edge as edge 0, DONE is entered at edge 3 + max(sa, sb) + (OP_W - sa - sb).
- Zero or small operands: the shift stops on co (7 shifts) even if the MSB never reaches 1; no special zero handling.

Optional Feature:
- Macro CAD_MULT_CYCLE_CNT_EN.
- Defined:
  - Adds output op_cycles[7:0].
  - An internal counter clears on entry to LOAD and increments in every non-IDLE cycle.
  - op_cycles is latched on entry to DONE and holds until the next DONE.
  - Reset value of op_cycles is 0.
- Undefined: the port and the counter are absent; the remaining behaviour is identical.

Test Plan:
- Reset, then A = B = 0x8000, start: no shift_en_a/b pulses, one ld_res, 16 shift_en_res pulses, done at edge 19, busy low the cycle after.
- A = 0x0100, B = 0x8000: 7 shift_en_a pulses, 0 shift_en_b, NORM stops on co_A, 9 result shifts, done at edge 19.
- A = B = 0x0001: 7 shifts each (co stop), rcnt = 2, done at edge 12.
- start held high during NORM/RSHIFT: no second LOAD until after DONE; start high in the cycle after DONE gives ld_a at the next edge.
- rst = 0 during RSHIFT: next cycle all outputs are 0, state is IDLE, no done; a fresh start then runs to completion normally.
- With CAD_MULT_CYCLE_CNT_EN: the first scenario gives op_cycles = 19; the value holds through IDLE until the next DONE.
